// File: rtl/sr_pkg.sv
// Shared definitions for the SR flip-flop bank: S=R=1 resolution modes,
// the per-channel request bundle and the next-state resolver.
package sr_pkg;

    localparam logic [1:0] MODE_HOLD    = 2'b00;
    localparam logic [1:0] MODE_SET_DOM = 2'b01;
    localparam logic [1:0] MODE_RST_DOM = 2'b10;
    localparam logic [1:0] MODE_TOGGLE  = 2'b11;

    typedef struct packed {
        logic s;
        logic r;
    } sr_req_t;

    function automatic logic sr_next(input logic q, input sr_req_t req, input logic [1:0] mode);
        logic nq;
        nq = q;
        unique case ({req.s, req.r})
            2'b10:   nq = 1'b1;
            2'b01:   nq = 1'b0;
            2'b11: begin
                unique case (mode)
                    MODE_SET_DOM: nq = 1'b1;
                    MODE_RST_DOM: nq = 1'b0;
                    MODE_TOGGLE:  nq = ~q;
                    default:      nq = q;
                endcase
            end
            default: nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// One channel: registered q with its registered complement, plus a sticky
// conflict flag that set-wins over the clear.
module sr_ff_cell
    import sr_pkg::*;
#(
    parameter bit INIT_VAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  sr_req_t    req,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       q,
    output logic       q_bar,
    output logic       conflict,
    output logic       conflict_flag
);

    assign conflict = en & req.s & req.r;

    // q_bar is its own flop loaded with the complement, so it never glitches against q.
    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= INIT_VAL;
            q_bar <= ~INIT_VAL;
        end else if (en) begin
            q     <= sr_next(q, req, mode);
            q_bar <= ~sr_next(q, req, mode);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            conflict_flag <= 1'b0;
        else if (conflict)
            conflict_flag <= 1'b1;
        else if (clr)
            conflict_flag <= 1'b0;
    end

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of N synchronous SR flip-flops with selectable S=R=1 resolution and a
// saturating bank-wide conflict counter.
module sr_ff_bank
    import sr_pkg::*;
#(
    parameter int N        = 4,
    parameter bit INIT_VAL = 1'b0,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     s,
    input  logic [N-1:0]     r,
    input  logic [1:0]       mode,
    input  logic             conflict_clr,
    output logic [N-1:0]     q,
    output logic [N-1:0]     q_bar,
    output logic [N-1:0]     conflict_flag,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N-1:0] conflict;
    logic         any_conflict;

    for (genvar i = 0; i < N; i++) begin : g_cell
        sr_ff_cell #(.INIT_VAL(INIT_VAL)) u_cell (
            .clk          (clk),
            .rst          (rst),
            .en           (en),
            .req          ('{s: s[i], r: r[i]}),
            .mode         (mode),
            .clr          (conflict_clr),
            .q            (q[i]),
            .q_bar        (q_bar[i]),
            .conflict     (conflict[i]),
            .conflict_flag(conflict_flag[i])
        );
    end

    assign any_conflict = |conflict;

    // One count per cycle however many channels collide; a same-cycle conflict survives the clear.
    always_ff @(posedge clk) begin
        if (rst)
            conflict_cnt <= '0;
        else if (conflict_clr)
            conflict_cnt <= any_conflict ? CNT_W'(1) : '0;
        else if (any_conflict && conflict_cnt != CNT_MAX)
            conflict_cnt <= conflict_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed bench for sr_ff_bank: two instances (INIT_VAL=0/CNT_W=4 and
// INIT_VAL=1/CNT_W=2) share stimulus and are checked against hand-computed tables.
module tb_sr_ff_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] s = '0;
    logic [3:0] r = '0;
    logic [1:0] mode = 2'b00;
    logic       conflict_clr = 1'b0;

    logic [3:0] q0, qb0, fl0, q1, qb1, fl1;
    logic [3:0] cnt0;
    logic [1:0] cnt1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sr_ff_bank #(.N(4), .INIT_VAL(1'b0), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .mode(mode),
        .conflict_clr(conflict_clr), .q(q0), .q_bar(qb0),
        .conflict_flag(fl0), .conflict_cnt(cnt0)
    );

    sr_ff_bank #(.N(4), .INIT_VAL(1'b1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .mode(mode),
        .conflict_clr(conflict_clr), .q(q1), .q_bar(qb1),
        .conflict_flag(fl1), .conflict_cnt(cnt1)
    );

    typedef struct {
        logic       rst, en, clr;
        logic [3:0] s, r;
        logic [1:0] mode;
        logic [3:0] eq0, eq1, eflag, ecnt0;
        logic [1:0] ecnt1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst_i, logic en_i, logic clr_i, logic [3:0] s_i,
                                logic [3:0] r_i, logic [1:0] m_i, logic [3:0] q0_i,
                                logic [3:0] q1_i, logic [3:0] f_i, logic [3:0] c0_i,
                                logic [1:0] c1_i);
        vec_t v;
        v.rst = rst_i; v.en = en_i; v.clr = clr_i; v.s = s_i; v.r = r_i; v.mode = m_i;
        v.eq0 = q0_i; v.eq1 = q1_i; v.eflag = f_i; v.ecnt0 = c0_i; v.ecnt1 = c1_i;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Apply one vector, clock it in, then check both instances just after the edge.
    task automatic apply(input vec_t v, input string tag);
        rst = v.rst; en = v.en; conflict_clr = v.clr; s = v.s; r = v.r; mode = v.mode;
        @(posedge clk);
        #1;
        chk({tag, " q0"},    {4'h0, q0},   {4'h0, v.eq0});
        chk({tag, " qbar0"}, {4'h0, qb0},  {4'h0, ~v.eq0});
        chk({tag, " q1"},    {4'h0, q1},   {4'h0, v.eq1});
        chk({tag, " qbar1"}, {4'h0, qb1},  {4'h0, ~v.eq1});
        chk({tag, " flag0"}, {4'h0, fl0},  {4'h0, v.eflag});
        chk({tag, " flag1"}, {4'h0, fl1},  {4'h0, v.eflag});
        chk({tag, " cnt0"},  {4'h0, cnt0}, {4'h0, v.ecnt0});
        chk({tag, " cnt1"},  {6'h0, cnt1}, {6'h0, v.ecnt1});
    endtask

    initial begin
        //              rst en clr s      r      mode   q0     q1     flag   c0  c1
        // reset with set requests pending
        vecs.push_back(mk(1, 1, 0, 4'hF, 4'h0, 2'b00, 4'h0, 4'hF, 4'h0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 4'hF, 4'h0, 2'b00, 4'h0, 4'hF, 4'h0, 0, 0));
        // basic set then reset, then enable low
        vecs.push_back(mk(0, 1, 0, 4'h5, 4'h0, 2'b00, 4'h5, 4'hF, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'h0, 4'h1, 2'b00, 4'h4, 4'hE, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'hF, 4'h0, 2'b00, 4'h4, 4'hE, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'hF, 4'hF, 2'b11, 4'h4, 4'hE, 4'h0, 0, 0));
        // mode sweep on ch0
        vecs.push_back(mk(0, 1, 0, 4'h1, 4'h1, 2'b00, 4'h4, 4'hE, 4'h1, 1, 1));
        vecs.push_back(mk(0, 1, 0, 4'h1, 4'h1, 2'b01, 4'h5, 4'hF, 4'h1, 2, 2));
        vecs.push_back(mk(0, 1, 0, 4'h1, 4'h1, 2'b10, 4'h4, 4'hE, 4'h1, 3, 3));
        vecs.push_back(mk(0, 1, 0, 4'h1, 4'h1, 2'b11, 4'h5, 4'hF, 4'h1, 4, 3));
        vecs.push_back(mk(0, 1, 0, 4'h1, 4'h1, 2'b11, 4'h4, 4'hE, 4'h1, 5, 3));
        vecs.push_back(mk(0, 1, 0, 4'h1, 4'h1, 2'b11, 4'h5, 4'hF, 4'h1, 6, 3));
        vecs.push_back(mk(0, 1, 1, 4'h0, 4'h0, 2'b00, 4'h5, 4'hF, 4'h0, 0, 0));
        // two channels conflicting: one count per cycle, CNT_W=2 saturates
        vecs.push_back(mk(0, 1, 0, 4'h3, 4'h3, 2'b00, 4'h5, 4'hF, 4'h3, 1, 1));
        vecs.push_back(mk(0, 1, 0, 4'h3, 4'h3, 2'b00, 4'h5, 4'hF, 4'h3, 2, 2));
        vecs.push_back(mk(0, 1, 0, 4'h3, 4'h3, 2'b00, 4'h5, 4'hF, 4'h3, 3, 3));
        vecs.push_back(mk(0, 1, 0, 4'h3, 4'h3, 2'b00, 4'h5, 4'hF, 4'h3, 4, 3));
        vecs.push_back(mk(0, 1, 0, 4'h3, 4'h3, 2'b00, 4'h5, 4'hF, 4'h3, 5, 3));
        vecs.push_back(mk(0, 0, 0, 4'h3, 4'h3, 2'b11, 4'h5, 4'hF, 4'h3, 5, 3));
        // clear colliding with a new conflict, then clear alone
        vecs.push_back(mk(0, 1, 1, 4'h4, 4'h4, 2'b00, 4'h5, 4'hF, 4'h4, 1, 1));
        vecs.push_back(mk(0, 1, 1, 4'h0, 4'h0, 2'b00, 4'h5, 4'hF, 4'h0, 0, 0));
        // clear with en low still clears
        vecs.push_back(mk(0, 1, 0, 4'h2, 4'h2, 2'b00, 4'h5, 4'hF, 4'h2, 1, 1));
        vecs.push_back(mk(0, 0, 1, 4'hF, 4'hF, 2'b11, 4'h5, 4'hF, 4'h0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Reset landing in the middle of toggle-mode activity
        apply(mk(0, 1, 0, 4'hF, 4'hF, 2'b11, 4'hA, 4'h0, 4'hF, 1, 1), "tog1");
        apply(mk(0, 1, 0, 4'hF, 4'hF, 2'b11, 4'h5, 4'hF, 4'hF, 2, 2), "tog2");
        apply(mk(1, 1, 0, 4'hF, 4'hF, 2'b11, 4'h0, 4'hF, 4'h0, 0, 0), "midrst");
        apply(mk(0, 1, 0, 4'hF, 4'hF, 2'b11, 4'hF, 4'h0, 4'hF, 1, 1), "resume1");
        apply(mk(0, 1, 0, 4'hF, 4'hF, 2'b11, 4'h0, 4'hF, 4'hF, 2, 2), "resume2");

        // mode change takes effect on the very next edge
        apply(mk(0, 1, 0, 4'hF, 4'hF, 2'b01, 4'hF, 4'hF, 4'hF, 3, 3), "modesw1");
        apply(mk(0, 1, 0, 4'hF, 4'hF, 2'b10, 4'h0, 4'h0, 4'hF, 4, 3), "modesw2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
